rf_writeback_arbiter: RTL and testbench
=======================================

// Module: rf_writeback_arbiter
// PURPOSE
// - Write-side initiator for the 32-entry register file: merges two result streams into its single write port (we/rW/din).
// - Source A (ALU, single-cycle) has priority. Source B (load/multi-cycle) is buffered in a FIFO.
// - Drops x0 writes and squashes stale B writes on WAW.
// - Reports pending-write hazards to the operand-read stage; forwarding data is optional.
// PARAMETERS
// - WIDTH       32  data width; matches register-file WIDTH
// - DEPTH       4   B FIFO entries (power of 2, >=2)
// - STARVE_MAX  8   consecutive non-pop cycles with B non-empty before B is forced
// PORTS
// - clk          in   1            clock
// - rst          in   1            reset, synchronous, active-high
// - a_valid      in   1            A request
// - a_ready      out  1            A accepted when a_valid&&a_ready
// - a_rd         in   5            A destination register
// - a_data       in   WIDTH        A result
// - b_valid      in   1            B request
// - b_ready      out  1            B accepted when b_valid&&b_ready
// - b_rd         in   5            B destination register
// - b_data       in   WIDTH        B result
// - wb_we        out  1            register-file write enable (registered)
// - wb_rd        out  5            register-file write index (registered)
// - wb_data      out  WIDTH        register-file write data (registered)
// - q1_rs,q2_rs  in   5            hazard query indices
// - q1_pend,q2_pend out 1          live pending write to queried register
// - q1_data,q2_data out WIDTH      forward data (RF_WB_BYPASS_EN only)
// - b_count      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset: wb_we=0, wb_rd=0, wb_data=0; FIFO empty; b_count=0; starve counter=0.
// - During rst: a_ready=0 and b_ready=0.
// - One slot per cycle, priority order:
//   (1) force: starve==STARVE_MAX && FIFO non-empty -> pop B head, a_ready=0.
//   (2) a_valid -> accept A, a_ready=1.
//   (3) FIFO non-empty -> pop B head.
//   (4) otherwise no slot.
// - Output registers: slot chosen in cycle N -> wb_* valid in cycle N+1; register file captures at the end of N+1.
// - wb_we=1 only when the slot carries a live entry with rd!=0. Otherwise wb_we=0 and wb_rd/wb_data hold.
// - a_ready is combinational = !rst && !force.
// - b_ready = !rst && !full. No push-when-full, even if a pop occurs that cycle.
// - Push and pop in the same cycle are legal; b_count is unchanged.
// - B with rd==0 is accepted but not stored.
// - Min B latency: push at edge N -> pop in N+1 -> wb_we in N+2.
// - Starve counter:
//   - +1 each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_MAX.
//   - Cleared on pop or when the FIFO is empty.
// - Ordering rule: B entries are always older than an A request in the same cycle.
// - WAW squash: A accepted with rd!=0 clears the live bit of every FIFO entry with rd==a_rd.
//   - This includes a B entry pushed in the same cycle with the same rd.
//   - Killed entries still pop and consume a slot, with wb_we=0.
// - Queries:
//   - qX_pend=1 if qX_rs!=0 and (any live FIFO entry rd==qX_rs, or wb_we&&wb_rd==qX_rs).
//   - Combinational; the same-cycle push/accept is not included.
// - Wrap-around: read/write pointers have one extra bit; full = MSBs differ && low bits equal.
// CONFIGURATION
// - Macro RF_WB_BYPASS_EN.
// - Defined:
//   - qX_data = data of the youngest live FIFO match; else wb_data if the wb register matches; else 0.
//   - Valid only when qX_pend=1.
// - Not defined: qX_data ports are absent; only pending flags are reported (consumer stalls).
// STRUCTURE
// - Package rf_wb_pkg:
//   - REG_IDX_W=5.
//   - typedef wb_req_t {logic [4:0] rd; logic [WIDTH-1:0] data; logic live;}.
//   - Function rd_match(a,b) returns a==b && a!=0.
// - Sub-module rf_wb_fifo: circular buffer of wb_req_t with parallel live-bit clear and per-entry compare outputs for queries/squash.
// TESTING
// - A only, rd=5, data=0xDEAD_BEEF at cycle 1 -> wb_we=1, wb_rd=5, wb_data=0xDEAD_BEEF in cycle 2.
// - B push rd=7, data=0x11, with a_valid held high -> B popped after 8 starve cycles; a_ready=0 that cycle; wb_rd=7 next cycle.
// - B rd=3 data=0xAA queued, then A rd=3 data=0xBB -> only one write, rd=3 data=0xBB; popped B slot has wb_we=0.
// - Push 4 B entries with no pop -> b_ready=0, b_count=4; pop one -> b_ready=1; rst mid-queue -> b_count=0, wb_we=0.
// - a_rd=0 and b_rd=0 requests -> both accepted, wb_we never asserts, b_count stays 0.
// - B rd=9 data=0x22 queued -> q1_rs=9 gives q1_pend=1 (q1_data=0x22 with RF_WB_BYPASS_EN); q2_rs=0 gives q2_pend=0.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared types and helpers for the register-file writeback arbiter.
package rf_wb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
    logic                 live;
  } wb_req_t;
  function automatic logic rd_match(input logic [REG_IDX_W-1:0] a, input logic [REG_IDX_W-1:0] b);
    return a == b && a != '0;
  endfunction
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: circular buffer of pending B writes with WAW live-bit kill and per-entry query compare.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  wb_req_t                         push_req_i,
  input  logic                            pop_i,
  input  logic                            kill_i,
  input  logic [REG_IDX_W-1:0]            kill_rd_i,
  input  logic [1:0][REG_IDX_W-1:0]       q_rs_i,
  output wb_req_t                         head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic [1:0]                      q_hit_o
`ifdef RF_WB_BYPASS_EN
  ,
  output logic [1:0][DATA_W-1:0]          q_data_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  wb_req_t     mem_q [DEPTH];
  logic [PW:0] wr_q, rd_q;
  logic [PW-1:0] idx;
  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head_o  = mem_q[rd_q[PW-1:0]];
  // Popping clears the live bit, so live alone marks an occupied, still-valid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && rd_match(mem_q[i].rd, kill_rd_i)) mem_q[i].live <= 1'b0;
      if (pop_i) begin
        mem_q[rd_q[PW-1:0]].live <= 1'b0;
        rd_q <= rd_q + (PW+1)'(1);
      end
      if (push_i) begin
        mem_q[wr_q[PW-1:0]].rd   <= push_req_i.rd;
        mem_q[wr_q[PW-1:0]].data <= push_req_i.data;
        mem_q[wr_q[PW-1:0]].live <= push_req_i.live && !(kill_i && rd_match(push_req_i.rd, kill_rd_i));
        wr_q <= wr_q + (PW+1)'(1);
      end
    end
  end
  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    q_hit_o = '0;
    idx = '0;
`ifdef RF_WB_BYPASS_EN
    q_data_o = '0;
`endif
    for (int q = 0; q < 2; q++)
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_q[PW-1:0] + PW'(k);
        if (mem_q[idx].live && rd_match(mem_q[idx].rd, q_rs_i[q])) begin
          q_hit_o[q] = 1'b1;
`ifdef RF_WB_BYPASS_EN
          q_data_o[q] = mem_q[idx].data;
`endif
        end
      end
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU (A) and buffered load (B) results into the single RF write port.
// Optional forwarding data on the query ports is enabled by defining RF_WB_BYPASS_EN.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [REG_IDX_W-1:0]     a_rd,
  input  logic [WIDTH-1:0]         a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [REG_IDX_W-1:0]     b_rd,
  input  logic [WIDTH-1:0]         b_data,
  output logic                     wb_we,
  output logic [REG_IDX_W-1:0]     wb_rd,
  output logic [WIDTH-1:0]         wb_data,
  input  logic [REG_IDX_W-1:0]     q1_rs,
  input  logic [REG_IDX_W-1:0]     q2_rs,
  output logic                     q1_pend,
  output logic                     q2_pend,
`ifdef RF_WB_BYPASS_EN
  output logic [WIDTH-1:0]         q1_data,
  output logic [WIDTH-1:0]         q2_data,
`endif
  output logic [$clog2(DEPTH):0]   b_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  wb_req_t              head, push_req;
  logic                 full, empty, force_pop, a_acc, pop, push;
  logic [1:0]           fifo_hit, wb_hit;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 wb_we_q, wb_we_d;
  logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]     wb_data_q, wb_data_d;
`ifdef RF_WB_BYPASS_EN
  logic [1:0][WIDTH-1:0] fifo_data;
`endif
  always_comb begin
    force_pop = starve_q == SW'(STARVE_MAX) && !empty;
    a_ready   = !rst && !force_pop;
    b_ready   = !rst && !full;
    a_acc     = a_valid && a_ready;
    pop       = !rst && !empty && !a_acc;
    push      = b_valid && b_ready && b_rd != '0;
    push_req  = '{rd: b_rd, data: b_data, live: 1'b1};
    wb_we_d   = a_acc ? a_rd != '0 : pop && head.live;
    wb_rd_d   = a_acc ? a_rd : head.rd;
    wb_data_d = a_acc ? a_data : head.data;
    starve_d  = (empty || pop) ? '0 : (starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + SW'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      starve_q  <= '0;
    end else begin
      wb_we_q  <= wb_we_d;
      starve_q <= starve_d;
      if (wb_we_d) begin
        wb_rd_q   <= wb_rd_d;
        wb_data_q <= wb_data_d;
      end
    end
  end
  // An accepted A is younger than everything queued, so it kills matching B entries.
  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_req_i (push_req),
    .pop_i      (pop),
    .kill_i     (a_acc),
    .kill_rd_i  (a_rd),
    .q_rs_i     ({q2_rs, q1_rs}),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (b_count),
    .q_hit_o    (fifo_hit)
`ifdef RF_WB_BYPASS_EN
    ,
    .q_data_o   (fifo_data)
`endif
  );
  always_comb begin
    wb_hit[0] = wb_we_q && rd_match(wb_rd_q, q1_rs);
    wb_hit[1] = wb_we_q && rd_match(wb_rd_q, q2_rs);
    q1_pend   = fifo_hit[0] || wb_hit[0];
    q2_pend   = fifo_hit[1] || wb_hit[1];
`ifdef RF_WB_BYPASS_EN
    q1_data   = fifo_hit[0] ? fifo_data[0] : (wb_hit[0] ? wb_data_q : '0);
    q2_data   = fifo_hit[1] ? fifo_data[1] : (wb_hit[1] ? wb_data_q : '0);
`endif
  end
  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: scoreboard bench for the register-file writeback arbiter.
module tb_rf_writeback_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0, q1_rs = '0, q2_rs = '0, wb_rd;
  logic [31:0] a_data = '0, b_data = '0, wb_data;
  logic        wb_we, q1_pend, q2_pend;
  logic [2:0]  b_count;
`ifdef RF_WB_BYPASS_EN
  logic [31:0] q1_data, q2_data;
`endif
  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  rf_writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .q1_rs(q1_rs), .q2_rs(q2_rs), .q1_pend(q1_pend), .q2_pend(q2_pend),
`ifdef RF_WB_BYPASS_EN
    .q1_data(q1_data), .q2_data(q2_data),
`endif
    .b_count(b_count)
  );
  // Every register-file write must match the oldest outstanding expectation.
  always @(negedge clk) if (wb_we === 1'b1) begin
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", wb_rd, wb_data);
    end else begin
      mon_e = exp_q.pop_front();
      if (wb_rd !== mon_e.rd || wb_data !== mon_e.data) begin
        errors++;
        $display("FAIL wb_write: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, mon_e.rd, mon_e.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb: got we=%b rd=%0d data=%h, required 0/0/0", wb_we, wb_rd, wb_data); end
    checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", b_count); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got a=%b b=%b, required 0/0", a_ready, b_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got a=%b b=%b, required 1/1", a_ready, b_ready); end
  endtask

  task automatic test_a_only();
    @(negedge clk); a_valid = 1; a_rd = 5; a_data = 32'hDEAD_BEEF; exp_q.push_back('{5'd5, 32'hDEAD_BEEF}); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %b, required 1", a_ready); end
    @(negedge clk); a_valid = 0; #1;
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_only_wb: got we=%b rd=%0d data=%h, required 1/5/deadbeef", wb_we, wb_rd, wb_data); end
    @(negedge clk); #1;
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd5) begin errors++; $display("FAIL a_only_hold: got we=%b rd=%0d, required 0/5", wb_we, wb_rd); end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_valid = 1; a_rd = 1; a_data = 32'h100 + i;
      b_valid = (i == 0); b_rd = 7; b_data = 32'h11;
      if (i == 9) exp_q.push_back('{5'd7, 32'h11}); else exp_q.push_back('{5'd1, 32'h100 + i});
      #1;
      checks++; if (a_ready !== (i != 9)) begin errors++; $display("FAIL starve_a_ready[%0d]: got %b, required %b", i, a_ready, i != 9); end
      if (i == 10) begin
        checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL starve_wb: got we=%b rd=%0d, required 1/7", wb_we, wb_rd); end
      end
    end
    @(negedge clk); a_valid = 0; b_valid = 0; #1;
    checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL starve_count: got %0d, required 0", b_count); end
  endtask

  task automatic test_waw();
    @(negedge clk); b_valid = 1; b_rd = 3; b_data = 32'hAA; #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL waw_b_ready: got %b, required 1", b_ready); end
    @(negedge clk); b_valid = 0; a_valid = 1; a_rd = 3; a_data = 32'hBB; q1_rs = 3; exp_q.push_back('{5'd3, 32'hBB}); #1;
    checks++; if (q1_pend !== 1'b1 || b_count !== 3'd1) begin errors++; $display("FAIL waw_queued: got pend=%b count=%0d, required 1/1", q1_pend, b_count); end
    @(negedge clk); a_valid = 0; #1;
    checks++; if (b_count !== 3'd1 || q1_pend !== 1'b1) begin errors++; $display("FAIL waw_killed_entry: got count=%0d pend=%b, required 1/1", b_count, q1_pend); end
`ifdef RF_WB_BYPASS_EN
    checks++; if (q1_data !== 32'hBB) begin errors++; $display("FAIL waw_fwd: got %h, required bb", q1_data); end
`endif
    @(negedge clk); #1;
    checks++; if (wb_we !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL waw_pop_dead: got we=%b count=%0d, required 0/0", wb_we, b_count); end
    @(negedge clk); a_valid = 1; a_rd = 4; a_data = 32'h44; b_valid = 1; b_rd = 4; b_data = 32'h55; exp_q.push_back('{5'd4, 32'h44});
    @(negedge clk); a_valid = 0; b_valid = 0; #1;
    checks++; if (b_count !== 3'd1) begin errors++; $display("FAIL waw_same_cycle_count: got %0d, required 1", b_count); end
    @(negedge clk); #1;
    checks++; if (wb_we !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL waw_same_cycle_pop: got we=%b count=%0d, required 0/0", wb_we, b_count); end
    q1_rs = 0;
  endtask

  task automatic test_full_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a_valid = 1; a_rd = 0; b_valid = 1; b_rd = 5'(10 + i); b_data = 32'h100 + i; #1;
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL fill_b_ready[%0d]: got %b, required 1", i, b_ready); end
    end
    @(negedge clk); b_rd = 14; #1;
    checks++; if (b_ready !== 1'b0 || b_count !== 3'd4) begin errors++; $display("FAIL full: got ready=%b count=%0d, required 0/4", b_ready, b_count); end
    @(negedge clk); a_valid = 0; exp_q.push_back('{5'd10, 32'h100}); #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_pop_no_push: got %b, required 0", b_ready); end
    @(negedge clk); a_valid = 1; b_valid = 0; #1;
    checks++; if (b_ready !== 1'b1 || b_count !== 3'd3) begin errors++; $display("FAIL after_pop: got ready=%b count=%0d, required 1/3", b_ready, b_count); end
    @(negedge clk); rst = 1; #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got a=%b b=%b, required 0/0", a_ready, b_ready); end
    @(negedge clk); rst = 0; a_valid = 0; #1;
    checks++; if (b_count !== 3'd0 || wb_we !== 1'b0) begin errors++; $display("FAIL mid_reset: got count=%0d we=%b, required 0/0", b_count, wb_we); end
  endtask

  task automatic test_x0();
    @(negedge clk); a_valid = 1; a_rd = 0; a_data = 32'hFFFF; b_valid = 1; b_rd = 0; b_data = 32'hEEEE; #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got a=%b b=%b, required 1/1", a_ready, b_ready); end
    @(negedge clk); a_valid = 0; #1;
    checks++; if (b_count !== 3'd0) begin errors++; $display("FAIL x0_count1: got %0d, required 0", b_count); end
    @(negedge clk); b_valid = 0; #1;
    checks++; if (b_count !== 3'd0 || wb_we !== 1'b0) begin errors++; $display("FAIL x0_count2: got count=%0d we=%b, required 0/0", b_count, wb_we); end
    @(negedge clk); #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b, required 0", wb_we); end
  endtask

  task automatic test_query();
    @(negedge clk); a_valid = 1; a_rd = 0; b_valid = 1; b_rd = 9; b_data = 32'h22; q1_rs = 9; q2_rs = 0; #1;
    checks++; if (q1_pend !== 1'b0) begin errors++; $display("FAIL q_same_cycle: got %b, required 0", q1_pend); end
    @(negedge clk); b_data = 32'h33; #1;
    checks++; if (q1_pend !== 1'b1 || q2_pend !== 1'b0) begin errors++; $display("FAIL q_pend: got q1=%b q2=%b, required 1/0", q1_pend, q2_pend); end
`ifdef RF_WB_BYPASS_EN
    checks++; if (q1_data !== 32'h22) begin errors++; $display("FAIL q_data1: got %h, required 22", q1_data); end
`endif
    @(negedge clk); b_valid = 0; q2_rs = 9; #1;
    checks++; if (q1_pend !== 1'b1 || q2_pend !== 1'b1) begin errors++; $display("FAIL q_pend2: got q1=%b q2=%b, required 1/1", q1_pend, q2_pend); end
`ifdef RF_WB_BYPASS_EN
    checks++; if (q1_data !== 32'h33 || q2_data !== 32'h33) begin errors++; $display("FAIL q_youngest: got q1=%h q2=%h, required 33/33", q1_data, q2_data); end
`endif
    @(negedge clk); a_valid = 0; exp_q.push_back('{5'd9, 32'h22});
    @(negedge clk); exp_q.push_back('{5'd9, 32'h33}); #1;
    checks++; if (q1_pend !== 1'b1) begin errors++; $display("FAIL q_fifo_over_wb: got %b, required 1", q1_pend); end
`ifdef RF_WB_BYPASS_EN
    checks++; if (q1_data !== 32'h33) begin errors++; $display("FAIL q_fifo_over_wb_data: got %h, required 33", q1_data); end
`endif
    @(negedge clk); #1;
    checks++; if (q1_pend !== 1'b1 || b_count !== 3'd0) begin errors++; $display("FAIL q_wb_only: got pend=%b count=%0d, required 1/0", q1_pend, b_count); end
    @(negedge clk); #1;
    checks++; if (q1_pend !== 1'b0 || q2_pend !== 1'b0) begin errors++; $display("FAIL q_idle: got q1=%b q2=%b, required 0/0", q1_pend, q2_pend); end
    q1_rs = 0; q2_rs = 0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_starve();
    test_waw();
    test_full_reset();
    test_x0();
    test_query();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
